// File: rtl/mul_execute_if.sv
// Execute-stage <-> multiply unit signal bundle: issue side from decode/execute,
// completion side back to writeback, plus the stall/flush controls.
interface mul_execute_if;
  logic [31:0] operand1_execute;
  logic [31:0] operand2_execute;
  logic        mul_execute;
  logic [4:0]  execute_type_execute;
  logic [4:0]  rd_execute;
  logic        reg_write_execute;
  logic        flush;
  logic        mul_stall;
  logic        mul_valid;
  logic [31:0] mul_result;
  logic [4:0]  mul_rd;
  logic        mul_reg_write;

  modport master (
    output operand1_execute, operand2_execute, mul_execute, execute_type_execute,
    output rd_execute, reg_write_execute, flush,
    input  mul_stall, mul_valid, mul_result, mul_rd, mul_reg_write
  );

  modport slave (
    input  operand1_execute, operand2_execute, mul_execute, execute_type_execute,
    input  rd_execute, reg_write_execute, flush,
    output mul_stall, mul_valid, mul_result, mul_rd, mul_reg_write
  );
endinterface

// File: rtl/mul_execute_unit.sv
// Sequential shift-add multiplier for MUL/MULH/MULHSU/MULHU: fixed 32-cycle
// magnitude multiply, sign applied at the end, one-cycle result strobe.
module mul_execute_unit (
  input  logic         clk,
  input  logic         rst_n,
  mul_execute_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t      state_r;
  logic [4:0]  count_r;
  logic [63:0] acc_r;
  logic [63:0] mcand_r;
  logic [31:0] mplier_r;
  logic        neg_r;
  logic        high_sel_r;
  logic [4:0]  rd_r;
  logic        reg_write_r;
  logic        valid_r;
  logic [31:0] result_r;
  logic [4:0]  mul_rd_r;
  logic        mul_wr_r;

  logic        op1_signed_s;
  logic        op2_signed_s;
  logic        high_sel_s;
  logic        sign1_s;
  logic        sign2_s;
  logic        accept_s;
  logic [63:0] acc_sum_s;
  logic [63:0] product_s;

  // Magnitude of an operand; 0x80000000 negates to itself, read as unsigned.
  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
    if (is_signed && v[31]) begin
      return ~v + 32'd1;
    end else begin
      return v;
    end
  endfunction

  function automatic logic [63:0] negate64(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction

  // Operand signedness and result-half selection per op code.
  always_comb begin
    op1_signed_s = 1'b1;
    op2_signed_s = 1'b1;
    high_sel_s   = 1'b0;
    case (bus.execute_type_execute)
      5'd1: begin op1_signed_s = 1'b1; op2_signed_s = 1'b1; high_sel_s = 1'b1; end
      5'd2: begin op1_signed_s = 1'b1; op2_signed_s = 1'b0; high_sel_s = 1'b1; end
      5'd3: begin op1_signed_s = 1'b0; op2_signed_s = 1'b0; high_sel_s = 1'b1; end
      default: begin op1_signed_s = 1'b1; op2_signed_s = 1'b1; high_sel_s = 1'b0; end
    endcase
  end

  assign sign1_s   = op1_signed_s & bus.operand1_execute[31];
  assign sign2_s   = op2_signed_s & bus.operand2_execute[31];
  assign accept_s  = (state_r == IDLE) & bus.mul_execute & ~bus.flush;
  assign acc_sum_s = acc_r + (mplier_r[0] ? mcand_r : 64'd0);
  assign product_s = neg_r ? negate64(acc_sum_s) : acc_sum_s;

  // Stall is combinational so decode holds in the accepting cycle; released in DONE.
  assign bus.mul_stall     = accept_s | ((state_r == BUSY) & ~bus.flush);
  assign bus.mul_valid     = valid_r & ~bus.flush;
  assign bus.mul_result    = result_r;
  assign bus.mul_rd        = mul_rd_r;
  assign bus.mul_reg_write = mul_wr_r & bus.mul_valid;

  // Control FSM, datapath registers and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      count_r     <= 5'd0;
      acc_r       <= 64'd0;
      mcand_r     <= 64'd0;
      mplier_r    <= 32'd0;
      neg_r       <= 1'b0;
      high_sel_r  <= 1'b0;
      rd_r        <= 5'd0;
      reg_write_r <= 1'b0;
      valid_r     <= 1'b0;
      result_r    <= 32'd0;
      mul_rd_r    <= 5'd0;
      mul_wr_r    <= 1'b0;
    end else if (bus.flush) begin
      state_r <= IDLE;
      count_r <= 5'd0;
      valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          valid_r <= 1'b0;
          if (bus.mul_execute) begin
            high_sel_r  <= high_sel_s;
            rd_r        <= bus.rd_execute;
            reg_write_r <= bus.reg_write_execute;
            neg_r       <= sign1_s ^ sign2_s;
            mcand_r     <= {32'd0, magnitude(bus.operand1_execute, op1_signed_s)};
            mplier_r    <= magnitude(bus.operand2_execute, op2_signed_s);
            acc_r       <= 64'd0;
            count_r     <= 5'd0;
            state_r     <= BUSY;
          end
        end
        BUSY: begin
          acc_r    <= acc_sum_s;
          mcand_r  <= {mcand_r[62:0], 1'b0};
          mplier_r <= {1'b0, mplier_r[31:1]};
          count_r  <= count_r + 5'd1;
          if (count_r == 5'd31) begin
            state_r  <= DONE;
            valid_r  <= 1'b1;
            result_r <= high_sel_r ? product_s[63:32] : product_s[31:0];
            mul_rd_r <= rd_r;
            mul_wr_r <= reg_write_r;
          end
        end
        DONE: begin
          valid_r <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          valid_r <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_execute_unit.sv
// Self-checking bench for mul_execute_unit: vector table through a result
// scoreboard, plus back-to-back, flush and mid-operation reset sequences.
module tb_mul_execute_unit;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        rw;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  mul_execute_if bus();

  mul_execute_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vecs[12];
  vec_t b2b1, b2b2, vflush, vrst, vafter;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference product built from sign-extended 64-bit multiplication.
  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic s1, s2;
    logic [63:0] ae, be, p;
    s1 = (op != 5'd3);
    s2 = (op != 5'd3) && (op != 5'd2);
    ae = s1 ? {{32{a[31]}}, a} : {32'd0, a};
    be = s2 ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ae * be;
    return (op == 5'd1 || op == 5'd2 || op == 5'd3) ? p[63:32] : p[31:0];
  endfunction

  function automatic vec_t mk(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] rd, input logic rw, input logic [31:0] exp);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.rd = rd; v.rw = rw; v.exp = exp;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.operand1_execute     = v.a;
    bus.operand2_execute     = v.b;
    bus.execute_type_execute = v.op;
    bus.rd_execute           = v.rd;
    bus.reg_write_execute    = v.rw;
    bus.mul_execute          = 1'b1;
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the first BUSY cycle.
  task automatic start_op(input vec_t v, input bit push);
    exp_t e;
    drive(v);
    #1;
    check("stall_accept", bus.mul_stall, 1'b1);
    if (push) begin
      e.res = v.exp; e.rd = v.rd; e.rw = v.rw;
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    bus.mul_execute = 1'b0;
  endtask

  // Waits for the result strobe; optionally presents the next multiply during DONE.
  task automatic await_result(input bit chain, input vec_t nxt);
    int   stall_cnt;
    bit   got;
    exp_t e;
    stall_cnt = 0;
    got = 1'b0;
    for (int k = 1; k <= 40 && !got; k++) begin
      if (bus.mul_valid) begin
        got = 1'b1;
        check("latency", k, 33);
        check("stall_cycles", stall_cnt, 32);
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL scoreboard: got unexpected result %0h, expected none", bus.mul_result);
        end else begin
          e = sb.pop_front();
          check("mul_result", bus.mul_result, e.res);
          check("mul_rd", bus.mul_rd, e.rd);
          check("mul_reg_write", bus.mul_reg_write, e.rw);
        end
        if (chain) begin
          drive(nxt);
          #1;
          check("stall_in_done", bus.mul_stall, 1'b0);
        end
      end else begin
        if (bus.mul_stall) stall_cnt++;
        @(negedge clk);
      end
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL valid_timeout: got no mul_valid, expected one within 40 cycles");
    end
  endtask

  task automatic count_valid(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.mul_valid) n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv;
    rst_n = 1'b0;
    bus.operand1_execute = 32'd0;
    bus.operand2_execute = 32'd0;
    bus.execute_type_execute = 5'd0;
    bus.rd_execute = 5'd0;
    bus.reg_write_execute = 1'b0;
    bus.mul_execute = 1'b0;
    bus.flush = 1'b0;

    @(negedge clk);
    check("rst_valid", bus.mul_valid, 1'b0);
    check("rst_stall", bus.mul_stall, 1'b0);
    check("rst_result", bus.mul_result, 32'd0);
    check("rst_rd", bus.mul_rd, 5'd0);
    check("rst_reg_write", bus.mul_reg_write, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Non-multiply instructions never stall.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.operand1_execute = $urandom;
      bus.execute_type_execute = 5'(i);
      #1;
      check("nonmul_stall", bus.mul_stall, 1'b0);
    end

    vecs[0]  = mk(5'd0, 32'd7,          32'd6,          5'd5,  1'b1, 32'h0000002A);
    vecs[1]  = mk(5'd1, 32'h80000000,   32'h80000000,   5'd1,  1'b1, 32'h40000000);
    vecs[2]  = mk(5'd0, 32'h80000000,   32'h80000000,   5'd2,  1'b1, 32'h00000000);
    vecs[3]  = mk(5'd2, 32'hFFFFFFFF,   32'hFFFFFFFF,   5'd3,  1'b1, 32'hFFFFFFFF);
    vecs[4]  = mk(5'd3, 32'hFFFFFFFF,   32'hFFFFFFFF,   5'd4,  1'b1, 32'hFFFFFFFE);
    vecs[5]  = mk(5'd7, 32'h12345678,   32'h9ABCDEF0,   5'd31, 1'b0, 32'h0);
    vecs[6]  = mk(5'd1, 32'hFFFFFFFD,   32'd7,          5'd6,  1'b1, 32'hFFFFFFFF);
    vecs[7]  = mk(5'd0, 32'd0,          32'd0,          5'd7,  1'b1, 32'h00000000);
    vecs[8]  = mk(5'd2, 32'h7FFFFFFF,   32'h80000000,   5'd8,  1'b1, 32'h0);
    vecs[9]  = mk(5'd3, 32'hDEADBEEF,   32'h00010000,   5'd9,  1'b1, 32'h0);
    vecs[10] = mk(5'(($urandom_range(0, 3))), $urandom, $urandom, 5'd10, 1'b1, 32'h0);
    vecs[11] = mk(5'(($urandom_range(0, 3))), $urandom, $urandom, 5'd11, 1'b0, 32'h0);
    for (int i = 5; i < 12; i++) begin
      if (i != 6 && i != 7) vecs[i].exp = model(vecs[i].op, vecs[i].a, vecs[i].b);
    end

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      start_op(vecs[i], 1'b1);
      await_result(1'b0, vecs[i]);
      @(negedge clk);
      check("valid_single_pulse", bus.mul_valid, 1'b0);
      check("result_hold", bus.mul_result, vecs[i].exp);
    end

    // Back-to-back: second multiply waits in the pipeline register during DONE.
    b2b1 = mk(5'd0, 32'd3, 32'd4, 5'd12, 1'b1, 32'h0000000C);
    b2b2 = mk(5'd0, 32'hFFFFFFFE, 32'd5, 5'd13, 1'b1, 32'hFFFFFFF6);
    @(negedge clk);
    start_op(b2b1, 1'b1);
    await_result(1'b1, b2b2);
    @(negedge clk);
    check("b2b_gap_valid", bus.mul_valid, 1'b0);
    start_op(b2b2, 1'b1);
    await_result(1'b0, b2b2);
    @(negedge clk);
    check("b2b_single_pulse", bus.mul_valid, 1'b0);

    // Flush while counter == 10 (eleventh BUSY cycle).
    vflush = mk(5'd0, 32'd9, 32'd9, 5'd14, 1'b1, 32'd81);
    @(negedge clk);
    start_op(vflush, 1'b0);
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    #1;
    check("flush_stall", bus.mul_stall, 1'b0);
    check("flush_valid", bus.mul_valid, 1'b0);
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    check("post_flush_valid", bus.mul_valid, 1'b0);
    check("post_flush_idle", bus.mul_stall, 1'b0);
    count_valid(40, nv);
    check("flush_no_valid", nv, 0);

    // Accumulator must start clean after an aborted multiply.
    vafter = mk(5'd0, 32'd11, 32'd13, 5'd15, 1'b1, 32'd143);
    @(negedge clk);
    start_op(vafter, 1'b1);
    await_result(1'b0, vafter);

    // Reset while counter == 20.
    vrst = mk(5'd3, 32'hFFFF0000, 32'h0000FFFF, 5'd16, 1'b1, 32'h0);
    @(negedge clk);
    @(negedge clk);
    start_op(vrst, 1'b0);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", bus.mul_valid, 1'b0);
    check("midrst_stall", bus.mul_stall, 1'b0);
    check("midrst_result", bus.mul_result, 32'd0);
    check("midrst_rd", bus.mul_rd, 5'd0);
    check("midrst_reg_write", bus.mul_reg_write, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    count_valid(40, nv);
    check("rst_no_valid", nv, 0);

    @(negedge clk);
    start_op(vecs[0], 1'b1);
    await_result(1'b0, vecs[0]);
    check("scoreboard_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
